elastic_pipe_reg: RTL and testbench

- Parametrised successor to the basic enable/flush pipeline register: a chain of STAGES valid/ready elastic stages, each a 2-entry skid buffer.
- Carries an N-bit payload between pipeline stages at full throughput.
- Back-pressure is registered, so in_ready never depends combinationally on out_ready.
- Synchronous flush kills all in-flight entries.
- Intended for decoupling IF/ID/EX boundaries where stalls originate downstream.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/elastic_pipe_reg_if.sv | 26 ++
 rtl/skid_slot.sv | 50 +++++
 rtl/elastic_pipe_reg.sv | 57 +++++
 tb/tb_elastic_pipe_reg.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and sizing helpers for the elastic pipeline register.
package pipe_pkg;
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} skid_state_e;

    function automatic int occ_w(input int stages);
        return $clog2(2 * stages + 1);
    endfunction
endpackage

// File: rtl/elastic_pipe_reg_if.sv
// elastic_pipe_reg_if: valid/ready handshake bundle plus flush and status.
interface elastic_pipe_reg_if
    import pipe_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 1
);
    logic                       flush;
    logic                       in_valid;
    logic [N-1:0]               in_data;
    logic                       in_ready;
    logic                       out_valid;
    logic [N-1:0]               out_data;
    logic                       out_ready;
    logic [occ_w(STAGES)-1:0]   occupancy;
    logic                       busy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, busy
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, busy
    );
endinterface

// File: rtl/skid_slot.sv
// skid_slot: one 2-entry skid buffer stage with registered back-pressure.
module skid_slot
    import pipe_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output skid_state_e  state
);
    logic         main_v, skid_v;
    logic [N-1:0] main_d, skid_d;
    logic         acc, pop;

    assign acc       = in_valid & in_ready;
    assign pop       = main_v & out_ready;
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign state     = skid_v ? ST_FULL : main_v ? ST_ONE : ST_EMPTY;

    // acc implies !skid_v, so a pop from FULL never coincides with an accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
        end else if (pop && skid_v) begin
            main_d <= skid_d;
            skid_v <= 1'b0;
        end else if (pop) begin
            main_v <= acc;
            if (acc) main_d <= in_data;
        end else if (acc && main_v) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
        end else if (acc) begin
            main_v <= 1'b1;
            main_d <= in_data;
        end
    end
endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: chain of STAGES skid slots carrying an N-bit payload
// at full throughput with registered back-pressure and synchronous flush.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 1
) (
    input logic                clk,
    input logic                rst,
    elastic_pipe_reg_if.slave  bus
);
    localparam int OW = occ_w(STAGES);

    logic [STAGES:0] v, r;
    logic [N-1:0]    d [STAGES+1];
    skid_state_e     st [STAGES];
    logic [OW-1:0]   occ, occ_sum;

    assign v[0]          = bus.in_valid;
    assign d[0]          = bus.in_data;
    assign r[STAGES]     = bus.out_ready;
    assign bus.in_ready  = r[0];
    assign bus.out_valid = v[STAGES];
    assign bus.out_data  = d[STAGES];
    assign bus.occupancy = occ;
    assign bus.busy      = |occ;

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        skid_slot #(.N(N)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush     (bus.flush),
            .in_valid  (v[i]),
            .in_data   (d[i]),
            .in_ready  (r[i]),
            .out_valid (v[i+1]),
            .out_data  (d[i+1]),
            .out_ready (r[i+1]),
            .state     (st[i])
        );
    end

    // Only block-boundary transfers change the total count
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.flush) occ <= '0;
        else occ <= occ + OW'(bus.in_valid & r[0]) - OW'(v[STAGES] & bus.out_ready);
    end

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++)
            occ_sum = occ_sum + ((st[i] == ST_FULL) ? OW'(2) : (st[i] == ST_ONE) ? OW'(1) : OW'(0));
    end

    occ_matches_slots: assert property (@(posedge clk) disable iff (rst) occ == occ_sum);
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: three DUTs (STAGES=1,2,3) checked by a FIFO scoreboard
// plus directed timing checks from hand-computed vectors.
module tb_elastic_pipe_reg;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         fl [3], iv [3], orr [3];
    logic [W-1:0] id [3];
    logic         ir [3], ov [3], bz [3];
    logic [W-1:0] od [3];
    logic [2:0]   occ [3];

    logic [W-1:0] q [3][$];
    logic         held [3];
    logic [W-1:0] held_d [3];
    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 3; g++) begin : u
        elastic_pipe_reg_if #(.N(W), .STAGES(g + 1)) bus ();
        assign bus.flush     = fl[g];
        assign bus.in_valid  = iv[g];
        assign bus.in_data   = id[g];
        assign bus.out_ready = orr[g];
        assign ir[g]  = bus.in_ready;
        assign ov[g]  = bus.out_valid;
        assign od[g]  = bus.out_data;
        assign bz[g]  = bus.busy;
        assign occ[g] = 3'(bus.occupancy);
        elastic_pipe_reg #(.N(W), .STAGES(g + 1)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s stages=%0d t=%0t: got %0h want %0h", nm, g + 1, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: inputs change just after posedge, so negedge sees
    // the settled handshake that the next rising edge will act on.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                q[g].delete();
                held[g] = 1'b0;
            end else begin
                chk("occupancy", g, occ[g], q[g].size());
                chk("busy", g, bz[g], q[g].size() != 0);
                if (q[g].size() == 0) chk("out_valid_empty", g, ov[g], 0);
                if (q[g].size() == 2 * (g + 1)) chk("in_ready_full", g, ir[g], 0);
                if (held[g]) begin
                    chk("hold_valid", g, ov[g], 1);
                    chk("hold_data", g, od[g], held_d[g]);
                end
                if (fl[g]) begin
                    q[g].delete();
                    held[g] = 1'b0;
                end else begin
                    if (ov[g] && orr[g]) begin
                        if (q[g].size() == 0) chk("pop_nonempty", g, 0, 1);
                        else chk("data_order", g, od[g], q[g].pop_front());
                    end
                    if (iv[g] && ir[g]) q[g].push_back(id[g]);
                    held[g]   = ov[g] && !orr[g];
                    held_d[g] = od[g];
                end
            end
        end
    end

    initial begin
        logic done;
        for (int g = 0; g < 3; g++) begin
            fl[g] = 0; iv[g] = 0; orr[g] = 1; id[g] = '0; held[g] = 0;
        end
        #12;
        for (int g = 0; g < 3; g++) begin
            chk("rst_out_valid", g, ov[g], 0);
            chk("rst_out_data", g, od[g], 0);
            chk("rst_in_ready", g, ir[g], 1);
            chk("rst_occupancy", g, occ[g], 0);
            chk("rst_busy", g, bz[g], 0);
        end
        step();
        rst = 0;
        step();

        // Reset mid-stream, STAGES=2
        orr[1] = 0; iv[1] = 1;
        id[1] = 8'h11; step();
        id[1] = 8'h22; step();
        id[1] = 8'h33; step();
        iv[1] = 0;
        chk("pre_rst_occ", 1, occ[1], 3);
        #2 rst = 1;
        #1;
        chk("async_rst_valid", 1, ov[1], 0);
        chk("async_rst_data", 1, od[1], 0);
        chk("async_rst_ready", 1, ir[1], 1);
        chk("async_rst_occ", 1, occ[1], 0);
        step();
        rst = 0; orr[1] = 1;
        step();

        // Full throughput, STAGES=3: item i accepted at edge i shows after edge i+2
        iv[2] = 1;
        for (int i = 1; i <= 16; i++) begin
            id[2] = W'(i);
            chk("stream_in_ready", 2, ir[2], 1);
            step();
            chk("stream_valid", 2, ov[2], i >= 3);
            if (i >= 3) chk("stream_data", 2, od[2], i - 2);
        end
        iv[2] = 0;
        step(); chk("stream_tail15", 2, od[2], 15);
        step(); chk("stream_tail16", 2, od[2], 16);
        step();

        // Stall fill, STAGES=2: four entries absorbed, fifth blocked
        orr[1] = 0; iv[1] = 1;
        for (int k = 0; k < 5; k++) begin
            id[1] = 8'hA0 + W'(k);
            chk("fill_in_ready", 1, ir[1], k < 4);
            if (k < 4) step();
        end
        step();
        chk("fill_blocked", 1, ir[1], 0);
        chk("fill_occ", 1, occ[1], 4);
        chk("fill_head", 1, od[1], 8'hA0);
        orr[1] = 1;
        done = 0;
        for (int c = 0; c < 20; c++) begin
            if (iv[1] && ir[1]) done = 1;
            step();
            if (done) iv[1] = 0;
        end
        chk("fill_a4_accepted", 1, done, 1);
        chk("fill_drained", 1, occ[1], 0);

        // Stall single, STAGES=1
        orr[0] = 0; iv[0] = 1;
        id[0] = 8'h55; step();
        id[0] = 8'h66; step();
        iv[0] = 0;
        chk("single_occ", 0, occ[0], 2);
        chk("single_ready", 0, ir[0], 0);
        chk("single_head", 0, od[0], 8'h55);
        step();
        chk("single_stable", 0, od[0], 8'h55);
        orr[0] = 1; step(); orr[0] = 0;
        chk("single_next", 0, od[0], 8'h66);
        chk("single_ready_back", 0, ir[0], 1);
        chk("single_occ1", 0, occ[0], 1);
        orr[0] = 1; step(); step();

        // Flush priority, STAGES=2
        orr[1] = 0; iv[1] = 1;
        for (int k = 0; k < 3; k++) begin
            id[1] = 8'hB0 + W'(k);
            step();
        end
        chk("pre_flush_occ", 1, occ[1], 3);
        fl[1] = 1; id[1] = 8'h77; orr[1] = 1;
        step();
        fl[1] = 0; iv[1] = 0;
        chk("flush_occ", 1, occ[1], 0);
        chk("flush_valid", 1, ov[1], 0);
        chk("flush_data", 1, od[1], 0);
        chk("flush_ready", 1, ir[1], 1);
        repeat (4) step();

        // Random traffic on all three DUTs
        for (int c = 0; c < 10000; c++) begin
            for (int g = 0; g < 3; g++) begin
                iv[g]  = $urandom_range(0, 2) != 0;
                id[g]  = W'($urandom);
                orr[g] = $urandom_range(0, 3) != 0;
                fl[g]  = $urandom_range(0, 49) == 0;
            end
            step();
        end
        for (int g = 0; g < 3; g++) begin
            iv[g] = 0; fl[g] = 0; orr[g] = 1;
        end
        repeat (10) step();
        for (int g = 0; g < 3; g++) chk("final_empty", g, q[g].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
